// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and line constants.
// Both the transmit and receive paths import this package.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int   UART_DATA_BITS            = 8;
  localparam logic UART_LINE_IDLE            = 1'b1;
  localparam int   UART_DEFAULT_CLKS_PER_BIT = 104;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side bundle of the UART transmitter: FIFO pop handshake plus line/status outputs.
interface uart_tx_if;
  import uart_pkg::*;

  // Handshake: fifo_empty low means fifo_out is valid in that same cycle; fifo_read_trig
  // is the one-cycle pop and is only raised while fifo_empty is low, so the head byte
  // is consumed in the cycle the strobe is high (zero read latency).
  logic                      enable;
  logic [UART_DATA_BITS-1:0] fifo_out;
  logic                      fifo_empty;
  logic                      fifo_read_trig;
  logic                      tx;
  logic                      busy;
  logic                      frame_done;

  modport master (
    output enable, fifo_out, fifo_empty,
    input  fifo_read_trig, tx, busy, frame_done
  );

  modport slave (
    input  enable, fifo_out, fifo_empty,
    output fifo_read_trig, tx, busy, frame_done
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter with synchronous clear; tick marks the last
// cycle of each bit period. Shared by the transmit and receive paths.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic nreset,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt <= '0;
    end else if (clear || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: pops one byte from the upstream FIFO and sends it as an
// 8N1/8N2 frame, LSB first, with busy and frame_done status for the host.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        nreset,
  uart_tx_if.slave    bus,
  output uart_state_e dbg_state
);

  localparam logic       STOP_LAST = (STOP_BITS == 2);
  localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      stop_cnt_q, stop_cnt_d;
  logic                      tx_q, tx_d;
  logic                      tick;
  logic                      last_stop;
  logic                      load;
  logic                      baud_clear;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .nreset(nreset),
    .clear (baud_clear),
    .tick  (tick)
  );

  assign last_stop  = (state_q == ST_STOP) && tick && (stop_cnt_q == STOP_LAST);
  // Gating with nreset keeps the pop strobe quiet while reset holds the FSM in IDLE.
  assign load       = nreset && bus.enable && !bus.fifo_empty &&
                      ((state_q == ST_IDLE) || last_stop);
  assign baud_clear = load || (state_q == ST_IDLE);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    if (load) begin
      state_d    = ST_START;
      shreg_d    = bus.fifo_out;
      bit_idx_d  = '0;
      stop_cnt_d = 1'b0;
    end else begin
      case (state_q)
        ST_START: if (tick) state_d = ST_DATA;
        ST_DATA: begin
          if (tick) begin
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == BIT_LAST) begin
              state_d    = ST_STOP;
              stop_cnt_d = 1'b0;
            end
          end
        end
        ST_STOP: begin
          if (last_stop) begin
            state_d    = ST_IDLE;
            stop_cnt_d = 1'b0;
          end else if (tick) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Line level is precomputed from next state so tx leaves a flop, not a decoder.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[0];
      default:  tx_d = UART_LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= UART_LINE_IDLE;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.fifo_read_trig = load;
  assign bus.tx             = tx_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.frame_done     = last_stop;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-window model checks instance A (4 clk/bit, 1 stop) every
// cycle; instance B (104 clk/bit, 2 stop) gets directed frame-timing checks.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB_A   = 4;
  localparam int SB_A    = 1;
  localparam int FRAME_A = (9 + SB_A) * CPB_A;
  localparam int CPB_B   = 104;
  localparam int SB_B    = 2;
  localparam int FRAME_B = (9 + SB_B) * CPB_B;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        nreset;
  uart_state_e dbg_a, dbg_b;

  uart_tx_if bus_a ();
  uart_tx_if bus_b ();

  uart_tx #(.CLKS_PER_BIT(CPB_A), .STOP_BITS(SB_A)) dut_a (
    .clk(clk), .nreset(nreset), .bus(bus_a), .dbg_state(dbg_a)
  );
  uart_tx #(.CLKS_PER_BIT(CPB_B), .STOP_BITS(SB_B)) dut_b (
    .clk(clk), .nreset(nreset), .bus(bus_b), .dbg_state(dbg_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         trig_cycles[$];
  int         exp_pops  = 0;
  int         pops_done = 0;
  int         dut_pops  = 0;
  bit         m_active  = 0;
  int         m_l       = 0;
  logic [7:0] m_byte    = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a frame loaded at cycle L owns cycles L+1..L+FRAME_A; bit slot k=(c-L-1)/CPB
  // is start (k=0), data bit k-1 (k=1..8) or stop; a new load is allowed when no frame
  // is active or in the active frame's final cycle.
  task automatic compare_loop();
    logic e_tx, e_busy, e_fd, e_load;
    int   k;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        m_active = 0;
        chk("rst_tx", bus_a.tx, 1);
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_frame_done", bus_a.frame_done, 0);
        chk("rst_trig", bus_a.fifo_read_trig, 0);
      end else begin
        if (m_active && cyc > m_l + FRAME_A) m_active = 0;
        e_tx   = 1'b1;
        e_busy = m_active;
        e_fd   = 1'b0;
        if (m_active) begin
          k = (cyc - m_l - 1) / CPB_A;
          if (k == 0) e_tx = 1'b0;
          else if (k <= 8) e_tx = m_byte[k-1];
          e_fd = (cyc == m_l + FRAME_A);
        end
        e_load = bus_a.enable && (fifo_q.size() > 0) && (!m_active || e_fd);
        chk("tx", bus_a.tx, e_tx);
        chk("busy", bus_a.busy, e_busy);
        chk("frame_done", bus_a.frame_done, e_fd);
        chk("fifo_read_trig", bus_a.fifo_read_trig, e_load);
        if (bus_a.fifo_read_trig) begin
          dut_pops++;
          trig_cycles.push_back(cyc);
        end
        if (e_load) begin
          m_l      = cyc;
          m_byte   = fifo_q[0];
          m_active = 1;
          exp_pops++;
          exp_q.push_back(fifo_q[0]);
        end
      end
      cyc++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_fifo();
    bus_a.fifo_empty = (fifo_q.size() == 0);
    bus_a.fifo_out   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_pops > pops_done) begin
      fifo_q.delete(0);
      pops_done++;
    end
    drive_fifo();
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    drive_fifo();
  endtask

  task automatic goto(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_trig_a(output int l, input int budget);
    l = -1;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (bus_a.fifo_read_trig === 1'b1) begin
        l = cyc;
        break;
      end
      tick();
    end
    chk("load_seen", (l >= 0), 1);
  endtask

  task automatic capture_byte(input int l, output logic [7:0] b);
    b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      goto(l + 1 + (k + 1) * CPB_A + 1);
      b[k] = bus_a.tx;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         l, l2, c0, p0, n0, bcnt, hi, fdc, lb, lb2;
    logic [9:0] wave;
    logic [7:0] got;

    nreset           = 1'b0;
    bus_a.enable     = 1'b0;
    drive_fifo();
    bus_b.enable     = 1'b0;
    bus_b.fifo_empty = 1'b1;
    bus_b.fifo_out   = 8'h00;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_a", bus_a.tx, 1);
    chk("reset_busy_a", bus_a.busy, 0);
    chk("reset_state_a", dbg_a, ST_IDLE);
    chk("reset_state_b", dbg_b, ST_IDLE);
    chk("reset_tx_b", bus_b.tx, 1);
    nreset = 1'b1;
    tick();

    // Single byte 0xA5: literal line waveform, LSB first
    bus_a.enable = 1'b1;
    p0 = dut_pops;
    c0 = cyc;
    push(8'hA5);
    wait_trig_a(l, 5);
    chk("a5_load_cycle", l, c0);
    wave = 10'b1101001010;
    for (int k = 0; k < 10; k++) begin
      goto(l + 1 + k * CPB_A + 1);
      chk("a5_bit", bus_a.tx, wave[k]);
    end
    goto(l + 40);
    chk("a5_frame_done", bus_a.frame_done, 1);
    goto(l + 41);
    chk("a5_busy_after", bus_a.busy, 0);
    chk("a5_pops", dut_pops - p0, 1);

    // Back-to-back 0x00, 0xFF, 0x55
    p0 = dut_pops;
    n0 = trig_cycles.size();
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    wait_trig_a(l, 5);
    bcnt = 0;
    for (int t = l + 1; t <= l + 120; t++) begin
      goto(t);
      if (bus_a.busy) bcnt++;
    end
    chk("b2b_busy_cycles", bcnt, 120);
    goto(l + 121);
    chk("b2b_busy_end", bus_a.busy, 0);
    chk("b2b_pops", dut_pops - p0, 3);
    if (trig_cycles.size() >= n0 + 3) begin
      chk("b2b_gap1", trig_cycles[n0+1] - trig_cycles[n0], 40);
      chk("b2b_gap2", trig_cycles[n0+2] - trig_cycles[n0+1], 40);
    end

    // Enable gating, enable drop mid-frame, empty FIFO
    bus_a.enable = 1'b0;
    p0 = dut_pops;
    push(8'h3C);
    repeat (30) tick();
    chk("disabled_pops", dut_pops - p0, 0);
    chk("disabled_tx", bus_a.tx, 1);
    bus_a.enable = 1'b1;
    wait_trig_a(l, 3);
    goto(l + 10);
    bus_a.enable = 1'b0;
    push(8'hC3);
    goto(l + 60);
    chk("drop_enable_pops", dut_pops - p0, 1);
    chk("drop_enable_busy", bus_a.busy, 0);
    bus_a.enable = 1'b1;
    wait_trig_a(l, 3);
    goto(l + 41);
    p0 = dut_pops;
    repeat (50) tick();
    chk("empty_pops", dut_pops - p0, 0);
    chk("empty_tx", bus_a.tx, 1);

    // Asynchronous reset during data bit 3, then a clean frame for the next byte
    push(8'h3C);
    push(8'h96);
    wait_trig_a(l, 3);
    goto(l + 18);
    chk("mid_state", dbg_a, ST_DATA);
    #1;
    nreset = 1'b0;
    #1;
    chk("async_rst_tx", bus_a.tx, 1);
    chk("async_rst_busy", bus_a.busy, 0);
    tick();
    tick();
    nreset = 1'b1;
    c0 = cyc;
    wait_trig_a(l2, 3);
    chk("rst_reload_cycle", l2, c0);
    capture_byte(l2, got);
    chk("rst_next_byte", got, 8'h96);
    goto(l2 + 41);

    // Head overwrite while a frame is in flight
    push(8'h12);
    push(8'h34);
    wait_trig_a(l, 3);
    goto(l + 6);
    fifo_q[0] = 8'hC7;
    drive_fifo();
    capture_byte(l, got);
    chk("ovw_inflight", got, 8'h12);
    wait_trig_a(l2, 50);
    chk("ovw_next_load", l2 - l, 40);
    capture_byte(l2, got);
    chk("ovw_next_byte", got, 8'hC7);
    chk("ovw_model_log", exp_q[exp_q.size()-1], 8'hC7);
    goto(l2 + 41);

    // Randomized traffic with enable toggling and write-while-full overwrites
    for (int i = 0; i < 1500; i++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 11) == 0) push(8'($urandom_range(0, 255)));
      else if (fifo_q.size() == 4 && $urandom_range(0, 7) == 0) begin
        fifo_q[0] = 8'($urandom_range(0, 255));
        drive_fifo();
      end
      if ($urandom_range(0, 149) == 0) bus_a.enable = ~bus_a.enable;
      tick();
    end
    bus_a.enable = 1'b1;
    for (int i = 0; i < 400 && (fifo_q.size() != 0 || bus_a.busy); i++) tick();
    chk("drain_done", (fifo_q.size() == 0) && !bus_a.busy, 1);
    chk("drain_state", dbg_a, ST_IDLE);

    // Instance B: two stop bits at 104 clk/bit, two back-to-back 0x01 frames
    bus_b.enable     = 1'b1;
    bus_b.fifo_out   = 8'h01;
    bus_b.fifo_empty = 1'b0;
    #1;
    chk("b_load", bus_b.fifo_read_trig, 1);
    lb  = cyc;
    lb2 = -1;
    fdc = -1;
    hi  = 0;
    for (int t = lb + 1; t <= lb + FRAME_B; t++) begin
      goto(t);
      if (bus_b.tx) hi++;
      if (bus_b.frame_done && fdc < 0) fdc = t;
      if (bus_b.fifo_read_trig && lb2 < 0) lb2 = t;
      if (t == lb + 936) chk("b_bit7_low", bus_b.tx, 0);
      if (t == lb + 937) chk("b_stop_start", bus_b.tx, 1);
    end
    chk("b_high_cycles", hi, 312);
    chk("b_frame_done", fdc - lb, 1144);
    chk("b_period", lb2 - lb, 1144);
    tick();
    bus_b.fifo_empty = 1'b1;
    if (lb2 >= 0) begin
      goto(lb2 + 1 + CPB_B + 1);
      chk("b2_bit0", bus_b.tx, 1);
      goto(lb2 + FRAME_B);
      chk("b2_frame_done", bus_b.frame_done, 1);
      goto(lb2 + FRAME_B + 1);
      chk("b2_busy_end", bus_b.busy, 0);
      chk("b2_tx_idle", bus_b.tx, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serializer stage directly downstream of the byte FIFO on the UART transmit path. Whenever the FIFO is non-empty and the engine is idle and enabled, it pops one byte and shifts it out on the `tx` line as an 8N1 (or 8N2) asynchronous frame, LSB first. It gives the host a `busy` indication and a one-cycle `frame_done` pulse.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per bit period (12 MHz / 115200 baud). Legal range is at least 2.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 or 2.
- `clk` in 1: single system clock. All state changes on its rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, no new frame is started. A frame already in flight always completes.
- `fifo_out` in 8: FIFO head byte. Combinational, valid in the same cycle while `fifo_empty` is low.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_read_trig` out 1: single-cycle pop strobe to the FIFO.
- `tx` out 1: serial line. Idle level is high.
- `busy` out 1: high from the cycle after a load until the end of the last stop-bit cycle.
- `frame_done` out 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- **States:** IDLE, START, DATA, STOP.
- **Load condition:** `load = enable && !fifo_empty && (state==IDLE || (state==STOP && last stop cycle))`.
- **On load:**
  - `shreg <= fifo_out`.
  - `fifo_read_trig` is 1 for exactly that cycle.
  - `state <= START`.
  - Baud counter is cleared and bit index is cleared.
- **START:** `tx=0` for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:** `tx=shreg[0]`. At each bit-period end, shift right and increment the bit index. After bit 7's period, go to STOP.
- **STOP:** `tx=1` for `STOP_BITS*CLKS_PER_BIT` cycles. At the end, either load (back-to-back) or go to IDLE.
- `fifo_read_trig` is never asserted while `fifo_empty` is high. At most one pop happens per frame.
- `tx` is registered: driven from the state/shift register, with no combinational path from inputs.
- **Width rules:**
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT-1`, and wraps to 0.
  - Bit index is 3 bits.
  - Stop-bit counter is 1 bit.
  - No other arithmetic.
- **Boundary cases:**
  - `enable` falling mid-frame: the frame finishes, then the engine idles.
  - `fifo_empty` rising during a frame has no effect until the next load decision.
  - If the FIFO overwrites its head on write-while-full, the byte latched at load is the one sent. `shreg` is never re-sampled.
- **Reset (including mid-frame):**
  - `tx=1`, `busy=0`, `frame_done=0`, `fifo_read_trig=0`, state IDLE, all counters 0, `shreg=0`.
  - A partially sent byte is lost, because it was already popped.

## Timing
- **Load to start bit:** load at cycle L, so `tx` falls at L+1.
- **Bit k (0..7) on `tx`:** cycles L+1+(k+1)·`CLKS_PER_BIT` through L+(k+2)·`CLKS_PER_BIT`.
- **Stop bit:** starts at L+1+9·`CLKS_PER_BIT`.
- **`frame_done`:** asserted at L+(9+`STOP_BITS`)·`CLKS_PER_BIT`.
- **Back-to-back frames:** consecutive start-bit falling edges are exactly (9+`STOP_BITS`)·`CLKS_PER_BIT` cycles apart, with no idle gap.
- **From IDLE:** load occurs in the first cycle with `enable && !fifo_empty`.
- **FIFO read latency:** zero. The FIFO head is consumed in the same cycle that `fifo_read_trig` is high.

## Structure
- **Shared package `uart_pkg`:**
  - State encoding (IDLE/START/DATA/STOP).
  - `UART_DATA_BITS=8`.
  - Line idle level constant.
  - Default `CLKS_PER_BIT`.
- The receive path reuses these.
- **Sub-module `uart_baud_counter`:**
  - Parameter `CLKS_PER_BIT`.
  - Inputs: `clk`, `nreset`, synchronous `clear`.
  - Output: one-cycle `tick` at count `CLKS_PER_BIT-1`.
  - The receive path reuses it.

## Test plan
- **Single byte:** `CLKS_PER_BIT=4`, `STOP_BITS=1`, FIFO holds 0xA5, `enable=1` → one `fifo_read_trig` pulse; `tx` is 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; `frame_done` at L+40; `busy` low afterwards.
- **Back-to-back:** 3 bytes 0x00, 0xFF, 0x55 queued → 3 pops; start edges 40 cycles apart; `tx` never idles between frames; `busy` stays high for 120 cycles.
- **Enable and empty gating:** `enable=0` with a non-empty FIFO → no pop and `tx` stays 1. Drop `enable` mid-frame → the frame completes and no further pop occurs. Empty FIFO with `enable=1` → `fifo_read_trig` is never asserted.
- **Async reset mid-frame:** `nreset` low during DATA bit 3 → `tx=1`, `busy=0` immediately, without waiting for a clock edge. After release, the next queued byte is sent with a correct frame.
- **Two stop bits:** `STOP_BITS=2`, `CLKS_PER_BIT=104`, byte 0x01 → stop high for 208 cycles; frame period is 1144 cycles.
- **FIFO overwrite:** FIFO overwrite during transmission → the in-flight byte is unchanged, and the next frame carries the FIFO head present at the next load.
